// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable access latency
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_to_proc
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]    cnt;
  logic [AW-1:0] req_index;
  logic          req_wr;
  logic [3:0]    req_mask;
  logic [31:0]   req_wdata;
  logic [31:0]   mem [DEPTH_WORDS];

  logic accept;
  logic access;

  // Byte offset and bits above the array span never select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ip_data_addr[31:AW+2], ip_data_addr[1:0]};

  assign accept        = (state == IDLE) && (ip_data_wr || ip_data_rd);
  assign access        = (state == BUSY) && (cnt == 4'd0);
  assign op_data_valid = (state == RESP);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: IDLE -> BUSY on a request, BUSY -> RESP at the access edge, RESP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ip_data_wr || ip_data_rd) state_next = BUSY;
      BUSY:    if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request on acceptance and count down the latency while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      req_index <= '0;
      req_wr    <= 1'b0;
      req_mask  <= 4'd0;
      req_wdata <= 32'd0;
    end else if (accept) begin
      cnt       <= 4'(LATENCY - 1);
      req_index <= ip_data_addr[AW+1:2];
      req_wr    <= ip_data_wr;
      req_mask  <= ip_data_mask;
      req_wdata <= ip_data_from_proc;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Read data updates only when a read completes; writes leave it untouched.
  always_ff @(posedge clk) begin
    if (reset)                  op_data_to_proc <= 32'd0;
    else if (access && !req_wr) op_data_to_proc <= mem[req_index];
  end

  // Byte-lane write at the access edge; a reset discards an in-flight write.
  always_ff @(posedge clk) begin
    if (!reset && access && req_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (req_mask[i]) mem[req_index][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] addr  [2];
  logic        wr    [2];
  logic        rd    [2];
  logic [3:0]  mask  [2];
  logic [31:0] wdata [2];
  logic        valid [2];
  logic [31:0] rdata [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [2][1024];
  logic [31:0] model_rd  [2];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .ip_data_addr(addr[0]), .ip_data_wr(wr[0]),
    .ip_data_mask(mask[0]), .ip_data_from_proc(wdata[0]), .ip_data_rd(rd[0]),
    .op_data_valid(valid[0]), .op_data_to_proc(rdata[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(reset), .ip_data_addr(addr[1]), .ip_data_wr(wr[1]),
    .ip_data_mask(mask[1]), .ip_data_from_proc(wdata[1]), .ip_data_rd(rd[1]),
    .op_data_valid(valid[1]), .op_data_to_proc(rdata[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] res;
    logic [31:0] bm;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        bm  = 32'hFF << (8 * i);
        res = (res & ~bm) | (nw & bm);
      end
    end
    return res;
  endfunction

  // Reference behaviour of one completed request: wr wins over rd.
  task automatic model_apply(input int d, input logic w, input logic r, input logic [31:0] a,
                             input logic [3:0] m, input logic [31:0] wd);
    if (w) model_mem[d][widx(a)] = merge(model_mem[d][widx(a)], wd, m);
    else if (r) model_rd[d] = model_mem[d][widx(a)];
  endtask

  // Issue one request, hold it until the valid pulse has ended, then drop it.
  task automatic do_txn(input int d, input logic w, input logic r, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] wd,
                        output int lat, output logic [31:0] got, output logic pulse_ok);
    @(negedge clk);
    addr[d] = a; wr[d] = w; rd[d] = r; mask[d] = m; wdata[d] = wd;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid[d]) begin
        lat = n;
        break;
      end
    end
    got = rdata[d];
    @(posedge clk); #1;
    pulse_ok = !valid[d] && (lat > 0);
    @(negedge clk);
    wr[d] = 1'b0; rd[d] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 0; wr[d] = 0; rd[d] = 0; mask[d] = 0; wdata[d] = 0; model_rd[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (valid[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", d, valid[d]); end
      checks++;
      if (rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdata[d]); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_word;
    int lat; logic [31:0] got; logic ok;
    do_txn(0, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF, lat, got, ok);
    model_apply(0, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF);
    checks++;
    if (lat !== 1 || !ok) begin errors++; $display("FAIL full_write_latency: got %0d pulse_ok %b expected 1", lat, ok); end
    do_txn(0, 0, 1, 32'h10, 4'h0, 32'h0, lat, got, ok);
    model_apply(0, 0, 1, 32'h10, 4'h0, 32'h0);
    checks++;
    if (lat !== 1 || !ok) begin errors++; $display("FAIL full_read_latency: got %0d pulse_ok %b expected 1", lat, ok); end
    checks++;
    if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL full_read_data: got %h expected deadbeef", got); end
  endtask

  task automatic test_byte_mask;
    int lat; logic [31:0] got; logic ok;
    do_txn(0, 1, 0, 32'h20, 4'hF, 32'h11223344, lat, got, ok);
    model_apply(0, 1, 0, 32'h20, 4'hF, 32'h11223344);
    do_txn(0, 1, 0, 32'h20, 4'b0101, 32'hAABBCCDD, lat, got, ok);
    model_apply(0, 1, 0, 32'h20, 4'b0101, 32'hAABBCCDD);
    do_txn(0, 0, 1, 32'h20, 4'h0, 32'h0, lat, got, ok);
    model_apply(0, 0, 1, 32'h20, 4'h0, 32'h0);
    checks++;
    if (got !== 32'h11BB33DD || got !== model_rd[0]) begin
      errors++; $display("FAIL byte_mask_data: got %h expected 11bb33dd", got);
    end
  endtask

  task automatic test_latency_hold;
    int lat; logic [31:0] got; logic ok;
    int edges[$];
    logic [31:0] first_data;
    do_txn(1, 1, 0, 32'h30, 4'hF, 32'hCAFEF00D, lat, got, ok);
    model_apply(1, 1, 0, 32'h30, 4'hF, 32'hCAFEF00D);
    checks++;
    if (lat !== 4 || !ok) begin errors++; $display("FAIL l4_write_latency: got %0d pulse_ok %b expected 4", lat, ok); end
    first_data = 32'h0;
    @(negedge clk);
    addr[1] = 32'h30; rd[1] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (valid[1]) begin
        if (edges.size() == 0) first_data = rdata[1];
        edges.push_back(n);
      end
    end
    @(negedge clk);
    rd[1] = 1'b0;
    repeat (6) @(posedge clk);
    model_apply(1, 0, 1, 32'h30, 4'h0, 32'h0);
    checks++;
    if (edges.size() !== 2) begin errors++; $display("FAIL hold_pulse_count: got %0d expected 2", edges.size()); end
    checks++;
    if (edges.size() < 1 || edges[0] !== 4) begin errors++; $display("FAIL hold_first_edge: got %0d expected 4", (edges.size() > 0) ? edges[0] : -1); end
    checks++;
    if (edges.size() < 2 || edges[1] !== 10) begin errors++; $display("FAIL hold_second_edge: got %0d expected 10", (edges.size() > 1) ? edges[1] : -1); end
    checks++;
    if (first_data !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_read_data: got %h expected cafef00d", first_data); end
  endtask

  task automatic test_mask_zero;
    int lat; logic [31:0] got; logic ok;
    do_txn(1, 1, 0, 32'h30, 4'h0, 32'h01234567, lat, got, ok);
    model_apply(1, 1, 0, 32'h30, 4'h0, 32'h01234567);
    checks++;
    if (lat !== 4 || !ok) begin errors++; $display("FAIL mask_zero_pulse: got %0d pulse_ok %b expected 4", lat, ok); end
    do_txn(1, 0, 1, 32'h30, 4'h0, 32'h0, lat, got, ok);
    model_apply(1, 0, 1, 32'h30, 4'h0, 32'h0);
    checks++;
    if (got !== 32'hCAFEF00D) begin errors++; $display("FAIL mask_zero_data: got %h expected cafef00d", got); end
  endtask

  task automatic test_wrap_conflict;
    int lat; logic [31:0] got; logic ok;
    do_txn(0, 1, 0, 32'h1000, 4'hF, 32'h55, lat, got, ok);
    model_apply(0, 1, 0, 32'h1000, 4'hF, 32'h55);
    do_txn(0, 0, 1, 32'h0, 4'h0, 32'h0, lat, got, ok);
    model_apply(0, 0, 1, 32'h0, 4'h0, 32'h0);
    checks++;
    if (got !== 32'h00000055) begin errors++; $display("FAIL wrap_read: got %h expected 00000055", got); end
    do_txn(0, 0, 1, 32'h3, 4'h0, 32'h0, lat, got, ok);
    model_apply(0, 0, 1, 32'h3, 4'h0, 32'h0);
    checks++;
    if (got !== 32'h00000055) begin errors++; $display("FAIL misaligned_read: got %h expected 00000055", got); end
    do_txn(0, 1, 1, 32'h0, 4'hF, 32'h99, lat, got, ok);
    model_apply(0, 1, 1, 32'h0, 4'hF, 32'h99);
    checks++;
    if (got !== 32'h00000055 || !ok) begin errors++; $display("FAIL conflict_rdata_held: got %h pulse_ok %b expected 00000055", got, ok); end
    do_txn(0, 0, 1, 32'h0, 4'h0, 32'h0, lat, got, ok);
    model_apply(0, 0, 1, 32'h0, 4'h0, 32'h0);
    checks++;
    if (got !== 32'h00000099) begin errors++; $display("FAIL conflict_was_write: got %h expected 00000099", got); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] got; logic ok;
    logic saw_valid;
    do_txn(1, 1, 0, 32'h40, 4'hF, 32'h12345678, lat, got, ok);
    model_apply(1, 1, 0, 32'h40, 4'hF, 32'h12345678);
    @(negedge clk);
    addr[1] = 32'h40; wr[1] = 1'b1; mask[1] = 4'hF; wdata[1] = 32'hFFFFFFFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid[1] !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", valid[1]); end
    checks++;
    if (rdata[1] !== 32'h0) begin errors++; $display("FAIL midreset_rdata: got %h expected 0", rdata[1]); end
    @(negedge clk);
    reset = 1'b0; wr[1] = 1'b0;
    model_rd[0] = 32'h0; model_rd[1] = 32'h0;
    saw_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (valid[1]) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_pulse: got %b expected 0", saw_valid); end
    do_txn(1, 0, 1, 32'h40, 4'h0, 32'h0, lat, got, ok);
    model_apply(1, 0, 1, 32'h40, 4'h0, 32'h0);
    checks++;
    if (got !== 32'h12345678) begin errors++; $display("FAIL midreset_write_discarded: got %h expected 12345678", got); end
  endtask

  task automatic test_random_program;
    int lat; logic [31:0] got; logic ok;
    logic w, r; logic [31:0] a; logic [3:0] m; logic [31:0] wd;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        wd = $urandom;
        a  = 32'h200 + 32'(4 * k);
        do_txn(d, 1, 0, a, 4'hF, wd, lat, got, ok);
        model_apply(d, 1, 0, a, 4'hF, wd);
      end
      for (int t = 0; t < 30; t++) begin
        case ($urandom_range(0, 3))
          0, 1: begin w = 1'b0; r = 1'b1; end
          2:    begin w = 1'b1; r = 1'b0; end
          default: begin w = 1'b1; r = 1'b1; end
        endcase
        a  = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3))
             + 32'h1000 * 32'($urandom_range(0, 1));
        m  = 4'($urandom_range(0, 15));
        wd = $urandom;
        do_txn(d, w, r, a, m, wd, lat, got, ok);
        model_apply(d, w, r, a, m, wd);
        checks++;
        if (lat !== lat_of(d) || !ok) begin
          errors++; $display("FAIL prog_latency[%0d] op %0d: got %0d pulse_ok %b expected %0d", d, t, lat, ok, lat_of(d));
        end
        checks++;
        if (got !== model_rd[d]) begin
          errors++; $display("FAIL prog_data[%0d] op %0d wr %b addr %h: got %h expected %h", d, t, w, a, got, model_rd[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_mask();
    test_latency_hold();
    test_mask_zero();
    test_wrap_conflict();
    test_reset_mid();
    test_random_program();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
